adc_series_framer: RTL

//  Sits directly downstream of the ADC trigger/capture stage. It accepts that stage's 32-bit tagged word stream, which has no tready.

---
 rtl/adc_stream_pkg.sv | 30 +++
 rtl/axis_word_fifo.sv | 78 +++++++
 rtl/adc_series_framer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_stream_pkg
// Purpose  : Shared definitions for the ADC series framer: the 2-bit word tags
//            carried in bits[31:30], the filler word used for burst padding,
//            the framing FSM state type and a tag legality helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package adc_stream_pkg;

  localparam logic [1:0]  TAG_SAMPLE = 2'b11;  // {a15,b15} sample pair
  localparam logic [1:0]  TAG_TS_LO  = 2'b01;  // trigger time, low 30 bits
  localparam logic [1:0]  TAG_TS_HI  = 2'b10;  // trigger time, high 30 bits (series end)
  localparam logic [1:0]  TAG_FILL   = 2'b00;  // never legal on the input

  localparam logic [31:0] FILL_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // between series
    ST_SAMP = 2'd1,  // receiving samples
    ST_TAIL = 2'd2   // low timestamp seen, waiting for high timestamp
  } frame_state_t;

  function automatic logic tag_is_legal(input logic [1:0] tag);
    return (tag != TAG_FILL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_word_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with an occupancy count.
//            The head word is visible on rd_data whenever empty is low, so a
//            word written in cycle N is readable in cycle N+1.
// Ports    : aclk, aresetn (async, active-low), clear (sync flush)
//            wr_en/wr_data  - write port (ignored when full)
//            rd_en/rd_data  - pop the head word (ignored when empty)
//            empty          - no word stored
//            count          - words stored, 0..2**ADDR_W
// Revision : 1.0  initial release
// ============================================================================
module axis_word_fifo #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int c_depth = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [c_depth];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_full;
  logic              w_wr;
  logic              w_rd;

  // Count reaches 2**ADDR_W only when full, so its MSB alone flags full.
  assign w_full  = r_count[ADDR_W];
  assign empty   = (r_count == '0);
  assign w_wr    = wr_en && !w_full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_series_framer.sv
`default_nettype none
// ============================================================================
// Module   : adc_series_framer
// Purpose  : Buffers the tagged ADC word stream (no back-pressure on input),
//            checks series framing (samples, low timestamp, high timestamp),
//            counts dropped words and completed series, and emits a DMA-ready
//            AXI-Stream with tlast every BURST_LEN beats and at series end.
// Ports    : aclk, aresetn (async, active-low), clear (sync flush/zero)
//            s_axis_tvalid/tdata            - tagged input words
//            m_axis_tvalid/tready/tdata/tlast - output stream
//            fifo_level    - words currently buffered
//            dropped_words - legal words lost to a full FIFO (saturating)
//            series_done   - completed series count (wrapping)
//            proto_err     - sticky framing / illegal-tag flag
// Config   : ADC_FRAMER_PAD_EN - pad short final bursts with FILL_WORD so
//            every burst is exactly BURST_LEN beats.
// Revision : 1.0  initial release
// ============================================================================
module adc_series_framer
  import adc_stream_pkg::*;
#(
  parameter int FIFO_AW   = 10,
  parameter int BURST_LEN = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               clear,
  input  logic               s_axis_tvalid,
  input  logic [31:0]        s_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tlast,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [31:0]        dropped_words,
  output logic [15:0]        series_done,
  output logic               proto_err
);

  localparam int BW = $clog2(BURST_LEN);

  // Full depth, and the sample admission limit that keeps two slots free
  // so a series tail can always be stored after a sample flood.
  localparam logic [FIFO_AW:0] c_depth      = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] c_samp_limit = {1'b0, {(FIFO_AW-1){1'b1}}, 1'b0};
  // BURST_LEN is a power of two, so its last beat index is all ones.
  localparam logic [BW-1:0]    c_beat_last  = '1;

  // ---------------------------------------------------------------- write side
  logic [1:0]        w_in_tag;
  logic              w_in_word;
  logic              w_legal;
  logic              w_store;
  logic              w_drop;
  logic              w_bad_tag;
  logic [FIFO_AW:0]  w_count;
  logic [31:0]       w_fifo_dout;
  logic              w_fifo_empty;
  logic              w_fifo_rd;

  assign w_in_tag  = s_axis_tdata[31:30];
  // clear takes priority: a word arriving with clear is simply discarded.
  assign w_in_word = s_axis_tvalid && !clear;
  assign w_legal   = tag_is_legal(w_in_tag);

  // Admission uses the count registered at the start of the cycle; a read in
  // the same cycle does not free space for this word.
  always_comb begin
    w_store = 1'b0;
    if (w_in_word) begin
      case (w_in_tag)
        TAG_SAMPLE:           w_store = (w_count < c_samp_limit);
        TAG_TS_LO, TAG_TS_HI: w_store = (w_count < c_depth);
        default:              w_store = 1'b0;
      endcase
    end
  end

  assign w_drop    = w_in_word && w_legal && !w_store;
  assign w_bad_tag = w_in_word && !w_legal;

  axis_word_fifo #(
    .ADDR_W (FIFO_AW),
    .DATA_W (32)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (clear),
    .wr_en   (w_store),
    .wr_data (s_axis_tdata),
    .rd_en   (w_fifo_rd),
    .rd_data (w_fifo_dout),
    .empty   (w_fifo_empty),
    .count   (w_count)
  );

  assign fifo_level = w_count;

  // ------------------------------------------------------------- framing FSM
  // Stepped by every legal word whether it was stored or dropped, so framing
  // reflects what the producer sent rather than what fit in the buffer.
  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic         w_frame_err;
  logic         w_series_end;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_err  = 1'b0;
    w_series_end = 1'b0;
    if (w_in_word && w_legal) begin
      case (r_state)
        ST_IDLE, ST_SAMP: begin
          case (w_in_tag)
            TAG_SAMPLE: w_state_nxt = ST_SAMP;
            TAG_TS_LO:  w_state_nxt = ST_TAIL;
            default:    w_frame_err = 1'b1;   // high timestamp without low
          endcase
        end
        ST_TAIL: begin
          case (w_in_tag)
            TAG_TS_HI: begin
              w_state_nxt  = ST_IDLE;
              w_series_end = 1'b1;
            end
            TAG_SAMPLE: begin
              w_state_nxt = ST_SAMP;
              w_frame_err = 1'b1;
            end
            default: w_frame_err = 1'b1;       // repeated low timestamp
          endcase
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dropped_words <= '0;
      series_done   <= '0;
      proto_err     <= 1'b0;
    end else if (clear) begin
      dropped_words <= '0;
      series_done   <= '0;
      proto_err     <= 1'b0;
    end else begin
      if (w_drop && (dropped_words != 32'hFFFF_FFFF)) begin
        dropped_words <= dropped_words + 32'd1;
      end
      if (w_series_end) begin
        series_done <= series_done + 16'd1;
      end
      if (w_bad_tag || w_frame_err) begin
        proto_err <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- output side
  logic          w_hs;
  logic          w_head_is_tail;
  logic [BW-1:0] r_beat_cnt;

  assign w_hs           = m_axis_tvalid && m_axis_tready;
  assign w_head_is_tail = (w_fifo_dout[31:30] == TAG_TS_HI);

`ifdef ADC_FRAMER_PAD_EN
  logic r_padding;
  logic w_pad_start;

  // A series end that falls short of a full burst opens a padding phase.
  assign w_pad_start = w_hs && !r_padding && w_head_is_tail
                       && (r_beat_cnt != c_beat_last);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_padding <= 1'b0;
    end else if (clear) begin
      r_padding <= 1'b0;
    end else if (w_pad_start) begin
      r_padding <= 1'b1;
    end else if (w_hs && r_padding && m_axis_tlast) begin
      r_padding <= 1'b0;
    end
  end

  // FIFO head is parked while filler beats are emitted; input keeps filling.
  assign m_axis_tvalid = r_padding || !w_fifo_empty;
  assign m_axis_tdata  = r_padding    ? FILL_WORD :
                         w_fifo_empty ? 32'h0000_0000 : w_fifo_dout;
  assign m_axis_tlast  = m_axis_tvalid && (r_beat_cnt == c_beat_last);
  assign w_fifo_rd     = w_hs && !r_padding;
`else
  assign m_axis_tvalid = !w_fifo_empty;
  // Memory is not reset; gate the head so idle outputs read as zero.
  assign m_axis_tdata  = w_fifo_empty ? 32'h0000_0000 : w_fifo_dout;
  assign m_axis_tlast  = !w_fifo_empty
                         && ((r_beat_cnt == c_beat_last) || w_head_is_tail);
  assign w_fifo_rd     = w_hs;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat_cnt <= '0;
    end else if (clear) begin
      r_beat_cnt <= '0;
    end else if (w_hs) begin
      r_beat_cnt <= m_axis_tlast ? '0 : r_beat_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
